// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the cpu_core slice.
//   - opcode values (instruction bits [6:0])
//   - branch condition codes (instruction bits [10:7] of a JMP)
//   - FSM state encoding and the debug snapshot struct
//   - bit positions of the instruction fields
//   - cond_met(): evaluates a condition code against the flags
package cpu_pkg;

    localparam logic [6:0] OP_NOP = 7'h00;
    localparam logic [6:0] OP_MOV = 7'h01;
    localparam logic [6:0] OP_LDI = 7'h02;
    localparam logic [6:0] OP_LD  = 7'h03;
    localparam logic [6:0] OP_LDR = 7'h04;
    localparam logic [6:0] OP_ST  = 7'h05;
    localparam logic [6:0] OP_STR = 7'h06;
    localparam logic [6:0] OP_ADD = 7'h07;
    localparam logic [6:0] OP_SUB = 7'h08;
    localparam logic [6:0] OP_AND = 7'h09;
    localparam logic [6:0] OP_OR  = 7'h0A;
    localparam logic [6:0] OP_XOR = 7'h0B;
    localparam logic [6:0] OP_SHL = 7'h0C;
    localparam logic [6:0] OP_SHR = 7'h0D;
    localparam logic [6:0] OP_CMP = 7'h0E;
    localparam logic [6:0] OP_ADI = 7'h0F;
    localparam logic [6:0] OP_JMP = 7'h10;

    localparam logic [3:0] CC_AL = 4'd0;
    localparam logic [3:0] CC_Z  = 4'd1;
    localparam logic [3:0] CC_NZ = 4'd2;
    localparam logic [3:0] CC_C  = 4'd3;
    localparam logic [3:0] CC_NC = 4'd4;
    localparam logic [3:0] CC_N  = 4'd5;
    localparam logic [3:0] CC_NN = 4'd6;

    localparam int OP_LSB  = 0;
    localparam int RD_LSB  = 7;
    localparam int RA_LSB  = 10;
    localparam int RB_LSB  = 13;
    localparam int CC_LSB  = 7;
    localparam int IMM_LSB = 16;

    typedef enum logic {
        ST_EXEC  = 1'b0,
        ST_MWAIT = 1'b1
    } state_t;

    typedef struct packed {
        state_t state;
        logic   z;
        logic   c;
        logic   n;
    } cpu_dbg_t;

    function automatic logic cond_met(input logic [3:0] cc, input logic z,
                                      input logic c, input logic n);
        logic taken;
        case (cc)
            CC_AL:   taken = 1'b1;
            CC_Z:    taken = z;
            CC_NZ:   taken = !z;
            CC_C:    taken = c;
            CC_NC:   taken = !c;
            CC_N:    taken = n;
            CC_NN:   taken = !n;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// cpu_alu: combinational 16-bit ALU.
//   op_i     : opcode (ADD/ADI add, SUB/CMP subtract, logic and shift ops)
//   a_i, b_i : operands (b_i[3:0] is the shift amount for SHL/SHR)
//   result_o : 16-bit result, modulo 2^16
//   z_o/n_o  : result zero / result bit 15
//   c_o      : carry-out for add, borrow for subtract, 0 for everything else
module cpu_alu
    import cpu_pkg::*;
(
    input  logic [6:0]  op_i,
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic [15:0] result_o,
    output logic        z_o,
    output logic        c_o,
    output logic        n_o
);

    logic [16:0] wide;

    always_comb begin
        wide     = '0;
        result_o = '0;
        c_o      = 1'b0;
        case (op_i)
            OP_ADD, OP_ADI: begin
                wide     = {1'b0, a_i} + {1'b0, b_i};
                result_o = wide[15:0];
                c_o      = wide[16];
            end
            OP_SUB, OP_CMP: begin
                // Bit 16 of the 17-bit difference is set exactly when a < b.
                wide     = {1'b0, a_i} - {1'b0, b_i};
                result_o = wide[15:0];
                c_o      = wide[16];
            end
            OP_AND:  result_o = a_i & b_i;
            OP_OR:   result_o = a_i | b_i;
            OP_XOR:  result_o = a_i ^ b_i;
            OP_SHL:  result_o = a_i << b_i[3:0];
            OP_SHR:  result_o = a_i >> b_i[3:0];
            default: result_o = '0;
        endcase
    end

    assign z_o = (result_o == 16'h0000);
    assign n_o = result_o[15];

endmodule

// File: rtl/cpu_core.sv
// cpu_core: 16-bit multi-cycle CPU, 32-bit instructions, 8x16 register file.
//   clk, rst_n           : clock, asynchronous active-low reset
//   prog_addr/instr_out  : program ROM address (= PC) and returned instruction
//   addr_bus/ram_in      : data address and store data (registered, held in MWAIT)
//   ram_out              : load data
//   ram_read/ram_write   : one-cycle load/store strobes
//   ram_busy/ram_ready   : memory handshake; an access finishes on the first
//                          cycle in MWAIT with ram_ready=1 and ram_busy=0
//   reg_leds/pc_leds     : r[LED_REG][7:0] and PC[3:0] for board debug
//   dbg_o                : FSM state and flags snapshot
module cpu_core
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int unsigned LED_REG  = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] prog_addr,
    input  logic [31:0] instr_out,
    output logic [15:0] addr_bus,
    output logic [15:0] ram_in,
    input  logic [15:0] ram_out,
    output logic        ram_read,
    output logic        ram_write,
    input  logic        ram_busy,
    input  logic        ram_ready,
    output logic [7:0]  reg_leds,
    output logic [3:0]  pc_leds,
    output cpu_dbg_t    dbg_o
);

    localparam logic [2:0] LED_IDX = 3'(LED_REG);

    state_t      state_q;
    logic [15:0] pc_q;
    logic [15:0] regs_q [8];
    logic        z_q, c_q, n_q;
    logic [15:0] addr_q, wdata_q;
    logic        rd_strobe_q, wr_strobe_q;
    logic        is_load_q;
    logic [2:0]  ld_rd_q;

    logic [6:0]  op;
    logic [2:0]  rd, ra, rb;
    logic [3:0]  cc;
    logic [15:0] imm, ra_val, rb_val, alu_b, alu_res, pc_inc;
    logic        alu_z, alu_c, alu_n;

    assign op     = instr_out[OP_LSB +: 7];
    assign rd     = instr_out[RD_LSB +: 3];
    assign ra     = instr_out[RA_LSB +: 3];
    assign rb     = instr_out[RB_LSB +: 3];
    assign cc     = instr_out[CC_LSB +: 4];
    assign imm    = instr_out[IMM_LSB +: 16];
    assign ra_val = regs_q[ra];
    assign rb_val = regs_q[rb];
    assign alu_b  = (op == OP_ADI) ? imm : rb_val;
    assign pc_inc = pc_q + 16'd1;

    cpu_alu u_alu (
        .op_i     (op),
        .a_i      (ra_val),
        .b_i      (alu_b),
        .result_o (alu_res),
        .z_o      (alu_z),
        .c_o      (alu_c),
        .n_o      (alu_n)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EXEC;
            pc_q        <= RESET_PC;
            for (int i = 0; i < 8; i++) regs_q[i] <= '0;
            z_q         <= 1'b0;
            c_q         <= 1'b0;
            n_q         <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rd_strobe_q <= 1'b0;
            wr_strobe_q <= 1'b0;
            is_load_q   <= 1'b0;
            ld_rd_q     <= '0;
        end else begin
            case (state_q)
                ST_EXEC: begin
                    case (op)
                        OP_MOV: begin regs_q[rd] <= ra_val; pc_q <= pc_inc; end
                        OP_LDI: begin regs_q[rd] <= imm;    pc_q <= pc_inc; end
                        // Memory ops leave PC alone; it advances when MWAIT completes.
                        OP_LD, OP_LDR: begin
                            addr_q      <= (op == OP_LD) ? imm : ra_val;
                            rd_strobe_q <= 1'b1;
                            is_load_q   <= 1'b1;
                            ld_rd_q     <= rd;
                            state_q     <= ST_MWAIT;
                        end
                        OP_ST, OP_STR: begin
                            addr_q      <= (op == OP_ST) ? imm : rb_val;
                            wdata_q     <= ra_val;
                            wr_strobe_q <= 1'b1;
                            is_load_q   <= 1'b0;
                            state_q     <= ST_MWAIT;
                        end
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
                        OP_SHL, OP_SHR, OP_ADI: begin
                            regs_q[rd] <= alu_res;
                            z_q        <= alu_z;
                            c_q        <= alu_c;
                            n_q        <= alu_n;
                            pc_q       <= pc_inc;
                        end
                        OP_CMP: begin
                            z_q  <= alu_z;
                            c_q  <= alu_c;
                            n_q  <= alu_n;
                            pc_q <= pc_inc;
                        end
                        OP_JMP:  pc_q <= cond_met(cc, z_q, c_q, n_q) ? imm : pc_inc;
                        default: pc_q <= pc_inc;
                    endcase
                end
                ST_MWAIT: begin
                    rd_strobe_q <= 1'b0;
                    wr_strobe_q <= 1'b0;
                    if (ram_ready && !ram_busy) begin
                        if (is_load_q) regs_q[ld_rd_q] <= ram_out;
                        pc_q    <= pc_inc;
                        state_q <= ST_EXEC;
                    end
                end
                default: state_q <= ST_EXEC;
            endcase
        end
    end

    assign prog_addr = pc_q;
    assign addr_bus  = addr_q;
    assign ram_in    = wdata_q;
    assign ram_read  = rd_strobe_q;
    assign ram_write = wr_strobe_q;
    assign reg_leds  = regs_q[LED_IDX][7:0];
    assign pc_leds   = pc_q[3:0];
    assign dbg_o     = '{state: state_q, z: z_q, c: c_q, n: n_q};

endmodule

// File: tb/tb_cpu_core.sv
// Bench for cpu_core. The bench plays the program ROM (it drives instr_out for
// the current PC) and the data memory. A reference model executes each
// instruction with plain integer arithmetic; directed tests check the
// documented scenarios and a randomized program checks PC, r0 and store data.
module tb_cpu_core;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] prog_addr, addr_bus, ram_in, ram_out;
    logic [31:0] instr_out;
    logic        ram_read, ram_write, ram_busy, ram_ready;
    logic [7:0]  reg_leds;
    logic [3:0]  pc_leds;
    cpu_dbg_t    dbg;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [15:0] m_r [8];
    logic [15:0] m_pc;
    logic        m_z, m_c, m_n;

    cpu_core dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .prog_addr (prog_addr),
        .instr_out (instr_out),
        .addr_bus  (addr_bus),
        .ram_in    (ram_in),
        .ram_out   (ram_out),
        .ram_read  (ram_read),
        .ram_write (ram_write),
        .ram_busy  (ram_busy),
        .ram_ready (ram_ready),
        .reg_leds  (reg_leds),
        .pc_leds   (pc_leds),
        .dbg_o     (dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_r[i] = '0;
        m_pc = 16'h0000;
        m_z  = 1'b0;
        m_c  = 1'b0;
        m_n  = 1'b0;
    endtask

    // ---------------- encoders ----------------
    function automatic logic [31:0] enc(input logic [6:0] op, input logic [2:0] rd,
                                        input logic [2:0] ra, input logic [2:0] rb,
                                        input logic [15:0] imm);
        return {imm, rb, ra, rd, op};
    endfunction

    function automatic logic [31:0] enc_jmp(input logic [3:0] cc, input logic [15:0] imm);
        return {imm, 5'b00000, cc, OP_JMP};
    endfunction

    // ---------------- reference model ----------------
    function automatic logic is_mem_op(input logic [31:0] ins);
        return ins[6:0] inside {OP_LD, OP_LDR, OP_ST, OP_STR};
    endfunction

    function automatic void model_exec(input logic [31:0] ins, input logic [15:0] ld_data);
        int unsigned a, b, im, res;
        logic        wr, fl, taken;
        a     = m_r[ins[12:10]];
        b     = m_r[ins[15:13]];
        im    = ins[31:16];
        res   = 0;
        wr    = 1'b0;
        fl    = 1'b0;
        m_pc  = 16'((int'(m_pc) + 1) % 65536);
        case (ins[6:0])
            OP_MOV: begin res = a; wr = 1; end
            OP_LDI: begin res = im; wr = 1; end
            OP_LD, OP_LDR: begin res = ld_data; wr = 1; end
            OP_ADD: begin res = a + b;  m_c = (res > 65535); wr = 1; fl = 1; end
            OP_ADI: begin res = a + im; m_c = (res > 65535); wr = 1; fl = 1; end
            OP_SUB: begin res = (a + 65536 - b) % 65536; m_c = (a < b); wr = 1; fl = 1; end
            OP_CMP: begin res = (a + 65536 - b) % 65536; m_c = (a < b); fl = 1; end
            OP_AND: begin res = a & b; m_c = 0; wr = 1; fl = 1; end
            OP_OR:  begin res = a | b; m_c = 0; wr = 1; fl = 1; end
            OP_XOR: begin res = a ^ b; m_c = 0; wr = 1; fl = 1; end
            OP_SHL: begin res = (a << (b % 16)) % 65536; m_c = 0; wr = 1; fl = 1; end
            OP_SHR: begin res = a >> (b % 16); m_c = 0; wr = 1; fl = 1; end
            OP_JMP: begin
                case (ins[10:7])
                    0: taken = 1;
                    1: taken = m_z;
                    2: taken = !m_z;
                    3: taken = m_c;
                    4: taken = !m_c;
                    5: taken = m_n;
                    6: taken = !m_n;
                    default: taken = 0;
                endcase
                if (taken) m_pc = 16'(im);
            end
            default: ;
        endcase
        res = res % 65536;
        if (fl) begin
            m_z = (res == 0);
            m_n = (res >= 32768);
        end
        if (wr) m_r[ins[9:7]] = 16'(res);
    endfunction

    // Runs one instruction against a fast memory (no checks).
    task automatic run_plain(input logic [31:0] ins);
        instr_out = ins;
        ram_busy  = 1'b0;
        ram_ready = 1'b1;
        model_exec(ins, ram_out);
        tick();
        if (is_mem_op(ins)) tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n     = 1'b0;
        instr_out = enc(OP_NOP, 0, 0, 0, 0);
        ram_out   = '0;
        ram_busy  = 1'b0;
        ram_ready = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        n_cmp++; if (prog_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_prog_addr: got %h want 0000", prog_addr); end
        n_cmp++; if (pc_leds !== 4'h0) begin n_fail++; $display("FAIL reset_pc_leds: got %h want 0", pc_leds); end
        n_cmp++; if (reg_leds !== 8'h00) begin n_fail++; $display("FAIL reset_reg_leds: got %h want 00", reg_leds); end
        n_cmp++; if ({ram_read, ram_write} !== 2'b00) begin n_fail++; $display("FAIL reset_strobes: got %b want 00", {ram_read, ram_write}); end
        n_cmp++; if ({addr_bus, ram_in} !== 32'h0) begin n_fail++; $display("FAIL reset_buses: got %h want 0", {addr_bus, ram_in}); end
        n_cmp++; if (dbg !== cpu_dbg_t'{state: ST_EXEC, z: 1'b0, c: 1'b0, n: 1'b0}) begin n_fail++; $display("FAIL reset_state_flags: got %b want 0000", dbg); end
        rst_n = 1'b1;
    endtask

    task automatic test_ldi();
        run_plain(enc(OP_LDI, 3'd0, 0, 0, 16'h00A5));
        n_cmp++; if (reg_leds !== 8'hA5) begin n_fail++; $display("FAIL ldi_reg_leds: got %h want a5", reg_leds); end
        n_cmp++; if (prog_addr !== 16'h0001) begin n_fail++; $display("FAIL ldi_prog_addr: got %h want 0001", prog_addr); end
    endtask

    task automatic test_flags_branch();
        run_plain(enc(OP_LDI, 3'd1, 0, 0, 16'hFFFF));
        run_plain(enc(OP_LDI, 3'd2, 0, 0, 16'h0001));
        run_plain(enc(OP_ADD, 3'd3, 3'd1, 3'd2, 16'h0000));
        n_cmp++; if (dbg.z !== 1'b1 || dbg.c !== 1'b1 || dbg.n !== 1'b0) begin n_fail++; $display("FAIL add_flags: got zcn=%b%b%b want 110", dbg.z, dbg.c, dbg.n); end
        run_plain(enc_jmp(CC_Z, 16'h0040));
        n_cmp++; if (prog_addr !== 16'h0040) begin n_fail++; $display("FAIL jmp_z: got %h want 0040", prog_addr); end
        run_plain(enc_jmp(CC_NC, 16'h0080));
        n_cmp++; if (prog_addr !== 16'h0041) begin n_fail++; $display("FAIL jmp_nc_not_taken: got %h want 0041", prog_addr); end
        run_plain(enc_jmp(CC_C, 16'h0050));
        n_cmp++; if (prog_addr !== 16'h0050) begin n_fail++; $display("FAIL jmp_c: got %h want 0050", prog_addr); end
        // Read r3 back through a store.
        instr_out = enc(OP_ST, 0, 3'd3, 0, 16'h4C10);
        model_exec(instr_out, ram_out);
        tick();
        n_cmp++; if (ram_in !== 16'h0000 || ram_write !== 1'b1) begin n_fail++; $display("FAIL add_r3_zero: got data %h wr %b want 0000 1", ram_in, ram_write); end
        tick();
    endtask

    task automatic test_store_busy();
        logic [15:0] pc0;
        pc0       = prog_addr;
        instr_out = enc(OP_ST, 0, 3'd1, 0, 16'h4C00);
        model_exec(instr_out, ram_out);
        tick();
        n_cmp++; if (ram_write !== 1'b1 || ram_read !== 1'b0) begin n_fail++; $display("FAIL st_strobe: got wr %b rd %b want 1 0", ram_write, ram_read); end
        n_cmp++; if (ram_in !== 16'hFFFF || addr_bus !== 16'h4C00) begin n_fail++; $display("FAIL st_bus: got %h@%h want ffff@4c00", ram_in, addr_bus); end
        ram_busy  = 1'b1;
        ram_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (ram_write !== 1'b0) begin n_fail++; $display("FAIL st_pulse_width: cycle %0d got %b want 0", i, ram_write); end
            n_cmp++; if (prog_addr !== pc0 || addr_bus !== 16'h4C00 || ram_in !== 16'hFFFF) begin n_fail++; $display("FAIL st_hold: cycle %0d got pc %h addr %h data %h", i, prog_addr, addr_bus, ram_in); end
        end
        ram_busy  = 1'b0;
        ram_ready = 1'b1;
        tick();
        n_cmp++; if (prog_addr !== pc0 + 16'd1) begin n_fail++; $display("FAIL st_release: got %h want %h", prog_addr, pc0 + 16'd1); end
    endtask

    task automatic test_load();
        logic [15:0] pc0;
        pc0       = prog_addr;
        ram_out   = 16'h0042;
        instr_out = enc(OP_LD, 3'd0, 0, 0, 16'h0000);
        model_exec(instr_out, ram_out);
        tick();
        n_cmp++; if (ram_read !== 1'b1 || addr_bus !== 16'h0000) begin n_fail++; $display("FAIL ld_strobe: got rd %b addr %h want 1 0000", ram_read, addr_bus); end
        n_cmp++; if (reg_leds !== 8'hA5) begin n_fail++; $display("FAIL ld_early: got %h want a5", reg_leds); end
        tick();
        n_cmp++; if (reg_leds !== 8'h42 || prog_addr !== pc0 + 16'd1) begin n_fail++; $display("FAIL ld_done: got leds %h pc %h want 42 %h", reg_leds, prog_addr, pc0 + 16'd1); end
    endtask

    task automatic test_reset_in_mwait();
        test_reset();
        ram_out   = 16'h0099;
        ram_busy  = 1'b1;
        ram_ready = 1'b0;
        instr_out = enc(OP_LD, 3'd0, 0, 0, 16'h0000);
        tick();
        tick();
        n_cmp++; if (dbg.state !== ST_MWAIT) begin n_fail++; $display("FAIL mwait_entered: got %b want %b", dbg.state, ST_MWAIT); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (prog_addr !== 16'h0000 || {ram_read, ram_write} !== 2'b00 || addr_bus !== 16'h0000 || dbg.state !== ST_EXEC) begin n_fail++; $display("FAIL mwait_reset: got pc %h strobes %b addr %h st %b", prog_addr, {ram_read, ram_write}, addr_bus, dbg.state); end
        ram_busy  = 1'b0;
        ram_ready = 1'b1;
        @(negedge clk);
        instr_out = enc(OP_NOP, 0, 0, 0, 0);
        rst_n     = 1'b1;
        model_reset();
        tick();
        model_exec(enc(OP_NOP, 0, 0, 0, 0), ram_out);
        n_cmp++; if (reg_leds !== 8'h00 || prog_addr !== 16'h0001) begin n_fail++; $display("FAIL mwait_abort: got leds %h pc %h want 00 0001", reg_leds, prog_addr); end
    endtask

    task automatic test_random();
        logic [31:0] ins;
        logic [15:0] exp_addr, exp_data, pc0, rdata;
        logic [6:0]  op;
        int          sel, busy;
        for (int i = 0; i < 300; i++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0: ins = enc(OP_LDI, 3'($urandom), 0, 0, 16'($urandom));
                1: ins = enc(OP_MOV, 3'($urandom), 3'($urandom), 0, 0);
                2, 3: ins = enc(7'($urandom_range(OP_ADD, OP_ADI)), 3'($urandom), 3'($urandom), 3'($urandom), 16'($urandom));
                4: ins = enc_jmp(4'($urandom), 16'($urandom));
                5: ins = enc(7'($urandom_range(17, 127)), 3'($urandom), 3'($urandom), 3'($urandom), 16'($urandom));
                default: ins = enc(7'($urandom_range(OP_LD, OP_STR)), 3'($urandom), 3'($urandom), 3'($urandom), 16'($urandom));
            endcase
            op       = ins[6:0];
            exp_addr = (op == OP_LDR) ? m_r[ins[12:10]] : (op == OP_STR) ? m_r[ins[15:13]] : ins[31:16];
            exp_data = m_r[ins[12:10]];
            pc0      = m_pc;
            rdata    = 16'($urandom);
            busy     = $urandom_range(0, 2);
            instr_out = ins;
            ram_out   = rdata;
            ram_busy  = 1'b0;
            ram_ready = 1'b1;
            model_exec(ins, rdata);
            tick();
            if (is_mem_op(ins)) begin
                n_cmp++;
                if (ram_read !== (op inside {OP_LD, OP_LDR}) || ram_write !== (op inside {OP_ST, OP_STR}) || addr_bus !== exp_addr) begin
                    n_fail++; $display("FAIL rnd_mem_req %0d: op %h got rd %b wr %b addr %h want addr %h", i, op, ram_read, ram_write, addr_bus, exp_addr);
                end
                if (op inside {OP_ST, OP_STR}) begin
                    n_cmp++; if (ram_in !== exp_data) begin n_fail++; $display("FAIL rnd_store_data %0d: got %h want %h", i, ram_in, exp_data); end
                end
                for (int w = 0; w < busy; w++) begin
                    case ($urandom_range(0, 2))
                        0: begin ram_busy = 1'b1; ram_ready = 1'b0; end
                        1: begin ram_busy = 1'b1; ram_ready = 1'b1; end
                        default: begin ram_busy = 1'b0; ram_ready = 1'b0; end
                    endcase
                    tick();
                    n_cmp++; if (prog_addr !== pc0 || ram_read !== 1'b0 || ram_write !== 1'b0) begin n_fail++; $display("FAIL rnd_wait %0d: got pc %h strobes %b want pc %h", i, prog_addr, {ram_read, ram_write}, pc0); end
                end
                ram_busy  = 1'b0;
                ram_ready = 1'b1;
                tick();
            end
            n_cmp++; if (prog_addr !== m_pc || reg_leds !== m_r[0][7:0]) begin n_fail++; $display("FAIL rnd_step %0d: op %h got pc %h leds %h want pc %h leds %h", i, op, prog_addr, reg_leds, m_pc, m_r[0][7:0]); end
        end
        // Dump every register through a store and compare full 16-bit values.
        for (int r = 0; r < 8; r++) begin
            ins       = enc(OP_ST, 0, 3'(r), 0, 16'(16'h5000 + r));
            exp_data  = m_r[r];
            instr_out = ins;
            model_exec(ins, ram_out);
            tick();
            n_cmp++; if (ram_in !== exp_data) begin n_fail++; $display("FAIL rnd_reg_dump r%0d: got %h want %h", r, ram_in, exp_data); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_ldi();
        test_flags_branch();
        test_store_busy();
        test_load();
        test_reset_in_mwait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
